// File: rtl/bch_128_pkg.sv
// Shared definitions for the (144,128) shortened binary BCH t=2 code over GF(2^8).
// Field constants, generator polynomial, power/inverse tables and position tables.
// Tables are built by constant functions at elaboration; nothing here is clocked.
package bch_128_pkg;

    localparam int N = 144;
    localparam int K = 128;
    localparam int T = 2;

    // Field polynomial x^8+x^4+x^3+x^2+1; m1 = field polynomial, m3 = minimal poly of alpha^3.
    localparam logic [8:0]  PRIM_POLY = 9'h11D;
    localparam logic [8:0]  M1_POLY   = 9'h11D;
    localparam logic [8:0]  M3_POLY   = 9'h177;
    // g(x) = m1(x) * m3(x), degree 16.
    localparam logic [16:0] GEN_POLY  = 17'h16F63;

    typedef logic [7:0] gf_t;
    typedef logic [255:0][7:0] gf_lut_t;
    typedef logic [N-1:0][7:0] pos_lut_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYND   = 3'd1,
        ST_LOC    = 3'd2,
        ST_SEARCH = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Multiply by alpha with reduction.
    function automatic gf_t gf_xtime(input gf_t a);
        gf_t r;
        r = {a[6:0], 1'b0};
        if (a[7]) r = r ^ PRIM_POLY[7:0];
        return r;
    endfunction

    // alpha^e for e = 0..254; entry 255 wraps to alpha^0.
    function automatic gf_lut_t gen_alpha_lut();
        gf_lut_t lut;
        gf_t     a;
        lut = '0;
        a   = 8'h01;
        for (int e = 0; e < 255; e++) begin
            lut[e] = a;
            a      = gf_xtime(a);
        end
        lut[255] = 8'h01;
        return lut;
    endfunction

    // Multiplicative inverse; inv(0) is defined as 0 and never used for a decision.
    function automatic gf_lut_t gen_inv_lut();
        gf_lut_t alog;
        gf_lut_t lut;
        alog = gen_alpha_lut();
        lut  = '0;
        for (int e = 0; e < 255; e++) begin
            lut[alog[e]] = alog[(255 - e) % 255];
        end
        return lut;
    endfunction

    // Per codeword position i (exponent 143-i): alpha^(mult*e), or its inverse.
    function automatic pos_lut_t gen_pos_lut(input int mult, input bit inverse);
        gf_lut_t  alog;
        pos_lut_t lut;
        int       e;
        alog = gen_alpha_lut();
        lut  = '0;
        for (int i = 0; i < N; i++) begin
            e = (mult * (N - 1 - i)) % 255;
            if (inverse) e = (255 - e) % 255;
            lut[i] = alog[8'(e)];
        end
        return lut;
    endfunction

    localparam gf_lut_t  ALPHA_LUT  = gen_alpha_lut();
    localparam gf_lut_t  INV_LUT    = gen_inv_lut();
    localparam pos_lut_t SYND1_LUT  = gen_pos_lut(1, 1'b0);
    localparam pos_lut_t SYND3_LUT  = gen_pos_lut(3, 1'b0);
    localparam pos_lut_t CHIEN1_LUT = gen_pos_lut(1, 1'b1);
    localparam pos_lut_t CHIEN2_LUT = gen_pos_lut(2, 1'b1);

endpackage

// File: rtl/bch_128_dec_gf256_mul.sv
// Combinational GF(2^8) multiplier, shift-and-add with per-step reduction.
// Latency: zero cycles (pure combinational).
// Backpressure: none; no handshake.
module gf256_mul
    import bch_128_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    gf_t acc;
    gf_t sh;

    // Accumulate a*alpha^k for every set bit k of b.
    always_comb begin
        acc = '0;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        p = acc;
    end

endmodule

// File: rtl/bch_128_dec.sv
// BCH(144,128) t=2 decoder: syndromes, closed-form locator, multi-cycle Chien search.
// Latency: o_valid rises 3 + 144/CHIEN_PAR edges after the accepting edge.
// Backpressure: one codeword in flight; enable is ignored while o_ready is low.
module bch_128_dec
    import bch_128_pkg::*;
#(
    parameter int CHIEN_PAR = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [0:143] i_code,
    output logic         o_ready,
    output logic [0:127] o_data,
    output logic [1:0]   o_err_cnt,
    output logic         o_uncorr,
    output logic         o_valid
);

    // CHIEN_PAR must divide 144 so the search covers every position exactly once.
    localparam int NCYC = N / CHIEN_PAR;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(NCYC - 1);

    state_t        state;
    logic [0:N-1]  code_q;
    logic [0:K-1]  data_orig;
    gf_t           s1_q;
    gf_t           s3_q;
    gf_t           sig1_q;
    gf_t           sig2_q;
    logic [1:0]    deg_q;
    logic          flag_q;
    logic [CW-1:0] cyc_q;
    logic [7:0]    roots_q;

    gf_t                  s1_c;
    gf_t                  s3_c;
    gf_t                  s1_sq;
    gf_t                  s1_cu;
    gf_t                  sig2_c;
    logic [CHIEN_PAR-1:0] root_vec;
    logic [7:0]           lane_pos [CHIEN_PAR];
    logic [0:N-1]         flip_c;
    logic [7:0]           cnt_c;
    logic                 uncorr_c;

    assign o_ready = (state == ST_IDLE);

    // Syndromes S1 = r(alpha), S3 = r(alpha^3) as XOR of per-position constants.
    always_comb begin
        s1_c = '0;
        s3_c = '0;
        for (int i = 0; i < N; i++) begin
            if (code_q[i]) begin
                s1_c = s1_c ^ SYND1_LUT[i];
                s3_c = s3_c ^ SYND3_LUT[i];
            end
        end
    end

    // sigma2 = (S3 + S1^3) / S1 for the two-error case.
    gf256_mul u_sq   (.a(s1_q),         .b(s1_q),          .p(s1_sq));
    gf256_mul u_cu   (.a(s1_sq),        .b(s1_q),          .p(s1_cu));
    gf256_mul u_sig2 (.a(s3_q ^ s1_cu), .b(INV_LUT[s1_q]), .p(sig2_c));

    // Each lane tests sigma(alpha^-(143-i)) = 0 for its position i this cycle.
    for (genvar j = 0; j < CHIEN_PAR; j++) begin : g_lane
        gf_t x1;
        gf_t x2;
        gf_t t1;
        gf_t t2;
        assign lane_pos[j] = 8'(cyc_q) * 8'(CHIEN_PAR) + 8'(j);
        assign x1 = CHIEN1_LUT[lane_pos[j]];
        assign x2 = CHIEN2_LUT[lane_pos[j]];
        gf256_mul u_m1 (.a(sig1_q), .b(x1), .p(t1));
        gf256_mul u_m2 (.a(sig2_q), .b(x2), .p(t2));
        assign root_vec[j] = ((8'h01 ^ t1 ^ t2) == 8'h00);
    end

    // Gather this cycle's roots into a flip mask and a root count.
    always_comb begin
        flip_c = '0;
        cnt_c  = '0;
        for (int j = 0; j < CHIEN_PAR; j++) begin
            if (root_vec[j]) flip_c[lane_pos[j]] = 1'b1;
            cnt_c = cnt_c + {7'd0, root_vec[j]};
        end
    end

    // Roots outside the shortened range leave count below degree: not correctable.
    assign uncorr_c = flag_q | (roots_q != {6'd0, deg_q});

    // Decoder FSM with all datapath and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            code_q    <= '0;
            data_orig <= '0;
            s1_q      <= '0;
            s3_q      <= '0;
            sig1_q    <= '0;
            sig2_q    <= '0;
            deg_q     <= '0;
            flag_q    <= 1'b0;
            cyc_q     <= '0;
            roots_q   <= '0;
            o_data    <= '0;
            o_err_cnt <= '0;
            o_uncorr  <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        code_q    <= i_code;
                        data_orig <= i_code[0:K-1];
                        cyc_q     <= '0;
                        roots_q   <= '0;
                        state     <= ST_SYND;
                    end
                end
                ST_SYND: begin
                    s1_q  <= s1_c;
                    s3_q  <= s3_c;
                    state <= ST_LOC;
                end
                ST_LOC: begin
                    if (s1_q == 8'h00) begin
                        // Zero S1 with nonzero S3 cannot come from one or two errors.
                        sig1_q <= '0;
                        sig2_q <= '0;
                        deg_q  <= 2'd0;
                        flag_q <= (s3_q != 8'h00);
                    end else if (s3_q == s1_cu) begin
                        sig1_q <= s1_q;
                        sig2_q <= '0;
                        deg_q  <= 2'd1;
                        flag_q <= 1'b0;
                    end else begin
                        sig1_q <= s1_q;
                        sig2_q <= sig2_c;
                        deg_q  <= 2'd2;
                        flag_q <= 1'b0;
                    end
                    state <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    // Full-length search regardless of degree keeps latency fixed.
                    code_q  <= code_q ^ flip_c;
                    roots_q <= roots_q + cnt_c;
                    if (cyc_q == LAST_CYC) begin
                        state <= ST_DONE;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_valid   <= 1'b1;
                    o_uncorr  <= uncorr_c;
                    o_data    <= uncorr_c ? data_orig : code_q[0:K-1];
                    o_err_cnt <= uncorr_c ? 2'd0 : deg_q;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bch_128_dec.md
Name: bch_128_dec

Overview:
Systematic decoder for the (144,128) shortened binary BCH code (t=2, GF(2^8)) that bch_128_enc produces. It accepts one 144-bit codeword, computes the syndromes, solves the error locator in closed form, and runs a multi-cycle Chien search. It returns the corrected 128-bit payload with an error count and an uncorrectable flag. It sits on the read path opposite the encoder and is intended for direct loopback with it.

Parameters:
CHIEN_PAR, 8, codeword positions evaluated per search cycle; must divide 144 (legal values 1,2,3,4,6,8,9,12,16,18,24,36,48,72,144).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  start request; sampled only while o_ready=1
i_code  input  [0:143]  codeword; [0:127] data, [128:143] parity; bit 0 = coefficient of x^143
o_ready  output  1  high in IDLE; decoder can accept a codeword
o_data  output  [0:127]  corrected data
o_err_cnt  output  2  errors corrected: 0, 1 or 2
o_uncorr  output  1  uncorrectable pattern detected; o_data = uncorrected input data
o_valid  output  1  one-cycle pulse; result outputs are valid

Behaviour:
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D). g(x)=m1(x)*m3(x), degree 16. Codeword bit i is the coefficient of x^(143-i).
- Reset (asynchronous): FSM=IDLE; o_ready=1; o_data=0, o_err_cnt=0, o_uncorr=0, o_valid=0; all internal registers cleared. Reset mid-decode aborts the decode with no o_valid.
- FSM states: IDLE -> SYND -> LOC -> SEARCH -> DONE -> IDLE.
- IDLE: on enable=1, latch i_code into the codeword register and go to SYND. When enable=0, stay in IDLE.
- SYND (1 cycle): register S1=r(alpha) and S3=r(alpha^3), both combinational over 144 bits.
- LOC (1 cycle), closed-form decision:
  - S1=0, S3=0: no error, deg=0.
  - S1!=0, S3=S1^3: deg=1, sigma1=S1, sigma2=0.
  - S1!=0 otherwise: deg=2, sigma1=S1, sigma2=(S3+S1^3)*inv(S1); inv is a 256-entry constant LUT.
  - S1=0, S3!=0: set the uncorrectable flag; deg=0.
- SEARCH: 144/CHIEN_PAR cycles. Cycle k evaluates sigma(alpha^-(143-i)) for positions i = k*CHIEN_PAR .. k*CHIEN_PAR+CHIEN_PAR-1. Each root flips bit i of the held codeword and increments the root count.
  - The search always runs its full length, whatever the LOC outcome, so latency is fixed.
- DONE (1 cycle):
  - If root count != deg, assert o_uncorr=1 and output the original data with o_err_cnt=0.
  - Otherwise, o_data = corrected [0:127] and o_err_cnt = deg.
  - o_valid=1 for exactly this cycle. Result outputs hold until the next DONE.
- Latency: enable sampled at edge E gives o_valid high after edge E+3+144/CHIEN_PAR (default: E+21). o_ready is low from E+1 until it returns high the cycle after DONE.
- enable while o_ready=0 is ignored; the input is not queued.
- Errors in parity bits [128:143] are located and counted but do not change o_data.
- Corrections for 1 or 2 errors anywhere in [0:143], including bits 0 and 143, are exact. Patterns of 3 or more errors produce either o_uncorr=1 or a miscorrection, matching the golden model.

Decomposition:
- Package bch_128_pkg holds:
  - primitive polynomial and generator constants;
  - N=144, K=128, T=2;
  - alpha-power table and inverse LUT as constant functions;
  - FSM state enum typedef.
- Sub-module gf256_mul: combinational 8x8 GF(2^8) multiplier, instantiated for the sigma2 computation and per-lane Chien evaluation.

Test Plan:
- Loopback with bch_128_enc: data 128'hb4705b94 encoded, then decoded -> o_data=128'hb4705b94, o_err_cnt=0, o_uncorr=0, o_valid exactly 21 cycles after enable.
- All-zero codeword with bit 5 flipped -> o_data=0, o_err_cnt=1, o_uncorr=0.
- Encoded 128'h5f9254db with bits 0 and 143 flipped -> o_data=128'h5f9254db, o_err_cnt=2.
- All-zero codeword with bits 1,2,3 flipped -> o_uncorr/o_err_cnt/o_data bit-exact to the Python golden model.
- Handshake and abort:
  - enable held high continuously: a second codeword is accepted only on the edge where o_ready=1;
  - reset_n pulsed low in SEARCH: all outputs return to 0 asynchronously, with no o_valid;
  - a subsequent decode is correct.
- CHIEN_PAR=1 and CHIEN_PAR=144 builds: the same two-error vector decodes identically, with latency 147 and 4 cycles respectively.
